// File: rtl/point_encode.sv
// Converts an extended-coordinate Ed25519 point (X:Y:Z) into its 32-byte compressed
// encoding: Z is inverted by Fermat exponentiation, then x and y are recovered with one shared multiplier.
module point_encode #(
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] x_in,
  input  logic [255:0] y_in,
  input  logic [255:0] z_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] enc_out,
  output logic         err
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // and enc_out/err stay stable after it until the next accepted start or reset.

  localparam logic [255:0] Q     = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] E_EXP = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

  typedef enum logic [2:0] {IDLE, LOAD, INV_SQ, INV_MUL, MUL_X, MUL_Y, DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_ITER, PH_COMMIT} phase_t;

  state_t       state_q, state_d;
  phase_t       phase;
  logic [255:0] xr, yr, zr, acc, r;
  logic [255:0] mul_a, mul_b, dbl, dbl_red, sum, step;
  logic [7:0]   it, bit_idx;
  logic         x_lsb;
  logic         mul_commit;
  logic         unused_top_bits;

  // Bit 255 of each input coordinate carries no information.
  assign unused_top_bits = ^{x_in[255], y_in[255], z_in[255]};

  function automatic logic [255:0] reduce_once(input logic [255:0] v);
    return (v >= Q) ? v - Q : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mul_commit = (phase == PH_COMMIT);
    mul_a      = acc;
    mul_b      = acc;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = INV_SQ;
      INV_SQ: begin
        if (mul_commit) begin
          if (E_EXP[bit_idx])     state_d = INV_MUL;
          else if (bit_idx == 0) state_d = MUL_X;
        end
      end
      INV_MUL: begin
        mul_b = zr;
        if (mul_commit) state_d = (bit_idx == 0) ? MUL_X : INV_SQ;
      end
      MUL_X: begin
        mul_a = xr;
        if (mul_commit) state_d = MUL_Y;
      end
      MUL_Y: begin
        mul_a = yr;
        if (mul_commit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One interleaved MSB-first step: r = 2r (+ a when b[it]) mod q; both operands stay < q.
  always_comb begin
    dbl     = r << 1;
    dbl_red = reduce_once(dbl);
    sum     = dbl_red + (mul_b[it] ? mul_a : 256'd0);
    step    = reduce_once(sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr      <= '0;
      yr      <= '0;
      zr      <= '0;
      acc     <= '0;
      r       <= '0;
      x_lsb   <= 1'b0;
      it      <= '0;
      bit_idx <= '0;
      phase   <= PH_SETUP;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      enc_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            xr      <= {1'b0, x_in[254:0]};
            yr      <= {1'b0, y_in[254:0]};
            zr      <= {1'b0, z_in[254:0]};
            acc     <= 256'd1;
            bit_idx <= 8'd254;
            phase   <= PH_SETUP;
            busy    <= 1'b1;
            err     <= 1'b0;
            enc_out <= '0;
          end
        end
        LOAD: begin
          xr <= reduce_once(xr);
          yr <= reduce_once(yr);
          zr <= reduce_once(zr);
        end
        INV_SQ, INV_MUL, MUL_X, MUL_Y: begin
          unique case (phase)
            PH_SETUP: begin
              r     <= '0;
              it    <= 8'd254;
              phase <= PH_ITER;
            end
            PH_ITER: begin
              r <= step;
              if (it == 0) phase <= PH_COMMIT;
              else         it    <= it - 8'd1;
            end
            default: begin
              phase <= PH_SETUP;
              unique case (state_q)
                INV_SQ: begin
                  acc <= r;
                  if (!E_EXP[bit_idx] && bit_idx != 0) bit_idx <= bit_idx - 8'd1;
                end
                INV_MUL: begin
                  acc <= r;
                  if (bit_idx != 0) bit_idx <= bit_idx - 8'd1;
                end
                MUL_X:   x_lsb <= r[0];
                default: yr    <= r;
              endcase
            end
          endcase
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (CHECK_ZERO && zr == '0) begin
            err     <= 1'b1;
            enc_out <= '0;
          end else begin
            err     <= 1'b0;
            enc_out <= {x_lsb, yr[254:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_encode.sv
// Self-checking bench for point_encode: scoreboarded encodings, done latency,
// start filtering, mid-operation reset and input-capture behaviour.
module tb_point_encode;

  localparam logic [255:0] Q       = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam int           LATENCY = 131072;
  localparam int           BUDGET  = 132000;

  logic         clk, rst, start;
  logic [255:0] x_in, y_in, z_in;
  logic         busy, done, err;
  logic [255:0] enc_out;

  logic [256:0] exp_q[$];
  int           vectors, miscompares;

  point_encode #(.CHECK_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .enc_out(enc_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start for a single cycle; returns #1 after the accepting edge.
  task automatic start_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                          input logic [255:0] exp_enc, input logic exp_err);
    @(negedge clk);
    x_in  = x;
    y_in  = y;
    z_in  = z;
    start = 1'b1;
    exp_q.push_back({exp_err, exp_enc});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; optionally re-pulses start or scrambles inputs.
  task automatic wait_done(input int restart_at, input bit scramble, output int cycles);
    cycles = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = n;
        break;
      end
      start = (n == restart_at);
      if (scramble) begin
        x_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        y_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        z_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    z_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (enc_out !== 256'd0) begin miscompares++; $display("FAIL reset_enc: got %h want 0", enc_out); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // X=1, Y=5, Z=1 with an extra start 100 cycles in that must be ignored.
  task automatic test_basic;
    int cycles;
    logic [256:0] exp;
    bit extra;
    start_op(256'd1, 256'd5, 256'd1, {1'b1, 255'd5}, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(100, 1'b0, cycles);
    exp = exp_q.pop_front();
    vectors++;
    if (cycles !== LATENCY) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", cycles, LATENCY); end
    vectors++;
    if (enc_out !== exp[255:0]) begin miscompares++; $display("FAIL basic_enc: got %h want %h", enc_out, exp[255:0]); end
    vectors++;
    if (err !== exp[256]) begin miscompares++; $display("FAIL basic_err: got %b want %b", err, exp[256]); end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    extra = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) extra = 1'b1;
    end
    vectors++;
    if (extra !== 1'b0) begin miscompares++; $display("FAIL basic_single_done: extra done got %b want 0", extra); end
  endtask

  // X=2, Y=10, Z=2 with inputs scrambled every cycle after capture.
  task automatic test_scaling_capture;
    int cycles;
    logic [256:0] exp;
    start_op(256'd2, 256'd10, 256'd2, {1'b1, 255'd5}, 1'b0);
    wait_done(-1, 1'b1, cycles);
    exp = exp_q.pop_front();
    vectors++;
    if (cycles !== LATENCY) begin miscompares++; $display("FAIL scale_latency: got %0d want %0d", cycles, LATENCY); end
    vectors++;
    if (enc_out !== exp[255:0]) begin miscompares++; $display("FAIL scale_enc: got %h want %h", enc_out, exp[255:0]); end
    vectors++;
    if (err !== exp[256]) begin miscompares++; $display("FAIL scale_err: got %b want %b", err, exp[256]); end
  endtask

  // Abort at +5000 with rst, then start on the first edge after release with the base point.
  task automatic test_abort_then_base;
    int cycles;
    logic [256:0] exp;
    bit seen;
    start_op(256'd1, 256'd7, 256'd3, 256'd0, 1'b0);
    void'(exp_q.pop_back());
    repeat (4999) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++;
    if (enc_out !== 256'd0) begin miscompares++; $display("FAIL abort_enc: got %h want 0", enc_out); end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b want 0", seen); end
    @(negedge clk);
    rst   = 1'b0;
    x_in  = 256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
    y_in  = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
    z_in  = 256'd1;
    start = 1'b1;
    exp_q.push_back({1'b0, 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658});
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL base_accept_busy: got %b want 1", busy); end
    wait_done(-1, 1'b0, cycles);
    exp = exp_q.pop_front();
    vectors++;
    if (cycles !== LATENCY) begin miscompares++; $display("FAIL base_latency: got %0d want %0d", cycles, LATENCY); end
    vectors++;
    if (enc_out !== exp[255:0]) begin miscompares++; $display("FAIL base_enc: got %h want %h", enc_out, exp[255:0]); end
    vectors++;
    if (err !== exp[256]) begin miscompares++; $display("FAIL base_err: got %b want %b", err, exp[256]); end
  endtask

  // Z = q+1 must reduce to 1 in LOAD.
  task automatic test_reduce;
    int cycles;
    logic [256:0] exp;
    start_op(256'd0, 256'd1, Q + 256'd1, 256'd1, 1'b0);
    wait_done(-1, 1'b0, cycles);
    exp = exp_q.pop_front();
    vectors++;
    if (cycles !== LATENCY) begin miscompares++; $display("FAIL reduce_latency: got %0d want %0d", cycles, LATENCY); end
    vectors++;
    if (enc_out !== exp[255:0]) begin miscompares++; $display("FAIL reduce_enc: got %h want %h", enc_out, exp[255:0]); end
    vectors++;
    if (err !== exp[256]) begin miscompares++; $display("FAIL reduce_err: got %b want %b", err, exp[256]); end
  endtask

  // Z = 0 flags err with a zero encoding after full latency.
  task automatic test_zero;
    int cycles;
    logic [256:0] exp;
    start_op(256'd0, 256'd1, 256'd0, 256'd0, 1'b1);
    wait_done(-1, 1'b0, cycles);
    exp = exp_q.pop_front();
    vectors++;
    if (cycles !== LATENCY) begin miscompares++; $display("FAIL zero_latency: got %0d want %0d", cycles, LATENCY); end
    vectors++;
    if (enc_out !== exp[255:0]) begin miscompares++; $display("FAIL zero_enc: got %h want %h", enc_out, exp[255:0]); end
    vectors++;
    if (err !== exp[256]) begin miscompares++; $display("FAIL zero_err: got %b want %b", err, exp[256]); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_scaling_capture();
    test_abort_then_base();
    test_reduce();
    test_zero();
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/point_encode.md
POINT_ENCODE -- requirements
Module: point_encode

Interface
REQ-001 SHALL have parameter CHECK_ZERO, default 1, meaning that when 1, Z == 0 is detected and flagged via err.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request encode; sampled only in IDLE.
REQ-005 SHALL have ports x_in, y_in, z_in, input, 256 bits each: extended-coordinate point (X:Y:Z) as produced by point_add, bit 255 ignored.
REQ-006 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse when enc_out/err are valid.
REQ-008 SHALL have port enc_out, output, 256 bits: compressed point, held until next accepted start or reset.
REQ-009 SHALL have port err, output, 1 bit: Z ≡ 0 mod q; valid with done, held like enc_out.

Function
REQ-010 SHALL compute x = X·Z^-1 mod q, y = Y·Z^-1 mod q, q = 2^255-19, and set enc_out = {x[0], y[254:0]} (RFC 8032 encoding).
REQ-011 SHALL capture x_in, y_in, z_in on the cycle start is accepted; later input changes have no effect.
REQ-012 SHALL reduce each captured value in [q, 2^255) by one conditional subtraction of q in state LOAD.
REQ-013 SHALL use one internal sequential modular multiplier:
  - interleaved MSB-first, r=0
  - for i=254..0: r=2r mod q, then if b[i], r=r+a mod q
  - one iteration per cycle, result always < q
REQ-014 SHALL cost each multiplication exactly 257 cycles: 1 setup cycle, 255 iteration cycles, 1 commit cycle.
REQ-015 SHALL compute Z^-1 as Z^(q-2) by left-to-right square-and-multiply:
  - acc=1
  - for i=254..0: acc=acc², then if e[i], acc=acc·Z
  - 255 squarings + 253 multiplies
REQ-016 SHALL then compute x = X·acc, then y = Y·acc: 510 multiplications in total.
REQ-017 SHALL implement the FSM IDLE -> LOAD -> INV_SQ <-> INV_MUL -> MUL_X -> MUL_Y -> DONE -> IDLE:
  - INV_SQ goes to INV_MUL if e[i]=1, else to the next bit's INV_SQ
  - after bit 0 it goes to MUL_X
  - DONE lasts one cycle
REQ-018 SHALL assert done exactly 1 + 510·257 + 1 = 131072 cycles after the start-accept edge (LOAD 1 cycle, DONE 1 cycle).
REQ-019 SHALL ignore start while busy; a start asserted during DONE is also ignored; start held high re-triggers only after returning to IDLE.
REQ-020 SHALL, when CHECK_ZERO=1 and reduced Z == 0, still run full latency and at done set err=1 and enc_out=0.
REQ-021 SHALL, when CHECK_ZERO=0, never assert err and produce whatever the arithmetic yields (enc_out=0 for Z=0).
REQ-022 SHALL use unsigned arithmetic only; intermediate sums 256 bits wide before conditional subtraction.

Reset
REQ-023 SHALL, on rst=1 (any time, including mid-operation):
  - enter IDLE asynchronously
  - clear busy, done, err, enc_out and all accumulators to 0
  - discard the in-flight operation
REQ-024 SHALL accept start on the first clock edge after rst deasserts.

Verification
REQ-025 SHALL pass: X=1, Y=5, Z=1, start -> done at +131072 cycles, enc_out = 2^255+5, err=0.
REQ-026 SHALL pass: X=2, Y=10, Z=2 -> enc_out = 2^255+5 (projective scaling invariance).
REQ-027 SHALL pass base point case: X=15112221349535400772501151409588531511454012693041857206046113283949847762202, Y=46316835694926478169428394003475163141307993866256225615783033603165251855960, Z=1 -> enc_out = 0x6666666666666666666666666666666666666666666666666666666666666658.
REQ-028 SHALL pass: X=0, Y=1, Z=q+1 (reduced to 1 at LOAD) -> enc_out = 1. X=0, Y=1, Z=0 -> err=1, enc_out=0.
REQ-029 SHALL pass: start, then a second start at +100 cycles -> ignored; single done at +131072. rst pulsed at +5000 -> busy=0 immediately, no done; next start completes normally.
REQ-030 SHALL pass: change x_in/y_in/z_in every cycle after start accepted -> result matches the captured values.
